// File: rtl/chopper_pkg.sv
// Shared definitions for the chopper sub-packet path: header field layout,
// read-scheduler state encoding and header length to word-count geometry.
package chopper_pkg;

  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned LEN_MSB  = 15;
  localparam int unsigned TYPE_LSB = 16;
  localparam int unsigned TYPE_MSB = 23;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_CAP,
    DATA,
    DONE
  } schedState_t;

  typedef struct packed {
    logic [15:0] words;
    logic [7:0]  lastMod;
  } pktGeom_t;

  // Word count is ceil(len / 2**lgBytes); the last word carries len mod bytes,
  // with a full word reported as the byte count rather than 0.
  function automatic pktGeom_t pktGeom(input logic [15:0] len, input int unsigned lgBytes);
    pktGeom_t    g;
    logic [15:0] rem;
    rem       = len & ((16'd1 << lgBytes) - 16'd1);
    g.words   = (len >> lgBytes) + {15'd0, (rem != 16'd0)};
    g.lastMod = (rem == 16'd0) ? 8'(32'd1 << lgBytes) : rem[7:0];
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with packet-granular pointer: the pointer
// only moves on an explicit advance pulse, never on grant alone.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/chopper_fifo_scheduler.sv
// Read-side scheduler for the two ping-pong sub-packet FIFOs: arbitrates per
// packet, parses the header and streams payload with Val/Sop/Eop/Mod framing.
module chopper_fifo_scheduler
  import chopper_pkg::*;
#(
  parameter int unsigned DAT_WIDTH   = 64,
  parameter logic [15:0] MAX_PKT_LEN = 16'd9600
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           fifo0_empty,
  input  logic                           fifo0_busy,
  output logic                           fifo0_rd,
  input  logic [DAT_WIDTH-1:0]           fifo0_data_out,
  input  logic                           fifo1_empty,
  input  logic                           fifo1_busy,
  output logic                           fifo1_rd,
  input  logic [DAT_WIDTH-1:0]           fifo1_data_out,
  input  logic                           Seq_Rdy,
  output logic                           Seq_Val,
  output logic                           Seq_Sop,
  output logic                           Seq_Eop,
  output logic [$clog2(DAT_WIDTH/8):0]   Seq_Mod,
  output logic [DAT_WIDTH-1:0]           Seq_Dat,
  output logic [15:0]                    Seq_PktLen,
  output logic [7:0]                     Seq_PktType,
  output logic                           Seq_Sel,
  output logic                           Seq_Error
);

  localparam int unsigned BYTES    = DAT_WIDTH / 8;
  localparam int unsigned LG_BYTES = $clog2(BYTES);
  localparam int unsigned MOD_W    = LG_BYTES + 1;

  schedState_t          state, stateNext;
  logic [1:0]           req, grant;
  logic                 advance, rdSel, rdData, rdOk, underrun, errNext;
  logic                 selEmpty, selBusy, lastWord;
  logic [DAT_WIDTH-1:0] curData;
  logic [63:0]          hdrWide;
  logic [15:0]          hdrLen;
  logic [7:0]           hdrType;
  logic                 hdrBad;
  logic                 unusedHdrBits;
  pktGeom_t             geom;
  logic [15:0]          wordsLeft;
  logic [MOD_W-1:0]     lastMod;
  logic                 sopPend;

  assign req = {(!fifo1_empty && !fifo1_busy), (!fifo0_empty && !fifo0_busy)};

  rr_arb2 uArb (
    .Clk     (Clk),
    .Rst     (Rst),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  assign selEmpty = Seq_Sel ? fifo1_empty : fifo0_empty;
  assign selBusy  = Seq_Sel ? fifo1_busy  : fifo0_busy;
  assign curData  = Seq_Sel ? fifo1_data_out : fifo0_data_out;

  // Header is widened so the type field exists even for 16-bit FIFOs.
  assign hdrWide       = 64'(curData);
  assign hdrLen        = hdrWide[LEN_MSB:LEN_LSB];
  assign hdrType       = hdrWide[TYPE_MSB:TYPE_LSB];
  assign unusedHdrBits = ^hdrWide[63:TYPE_MSB+1];
  assign hdrBad        = (hdrLen == 16'd0) || (hdrLen > MAX_PKT_LEN);
  assign geom          = pktGeom(hdrLen, LG_BYTES);

  assign lastWord = (wordsLeft == 16'd1);
  assign rdOk     = Seq_Rdy && !selEmpty && (wordsLeft != 16'd0);
  assign underrun = selEmpty && !selBusy && (wordsLeft != 16'd0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    rdSel     = 1'b0;
    advance   = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) stateNext = HDR_RD;
      end
      HDR_RD: begin
        rdSel     = 1'b1;
        stateNext = HDR_CAP;
      end
      HDR_CAP: begin
        if (hdrBad) begin
          errNext   = 1'b1;
          advance   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = DATA;
        end
      end
      DATA: begin
        if (rdOk) begin
          rdSel = 1'b1;
          if (lastWord) stateNext = DONE;
        end else if (underrun) begin
          errNext   = 1'b1;
          advance   = 1'b1;
          stateNext = IDLE;
        end
      end
      DONE: begin
        advance   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rdData   = rdSel && (state == DATA);
  assign fifo0_rd = rdSel && !Seq_Sel;
  assign fifo1_rd = rdSel && Seq_Sel;

  // FIFO read data lands one cycle after the strobe, aligned with Seq_Val.
  assign Seq_Dat = Seq_Val ? curData : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Seq_Val     <= 1'b0;
      Seq_Sop     <= 1'b0;
      Seq_Eop     <= 1'b0;
      Seq_Mod     <= '0;
      Seq_PktLen  <= '0;
      Seq_PktType <= '0;
      Seq_Sel     <= 1'b0;
      Seq_Error   <= 1'b0;
      wordsLeft   <= '0;
      lastMod     <= '0;
      sopPend     <= 1'b0;
    end else begin
      Seq_Val   <= rdData;
      Seq_Sop   <= rdData && sopPend;
      Seq_Eop   <= rdData && lastWord;
      Seq_Mod   <= rdData ? (lastWord ? lastMod : MOD_W'(BYTES)) : '0;
      Seq_Error <= errNext;
      if (state == IDLE && grant != 2'b00) begin
        Seq_Sel <= grant[1];
      end
      if (state == HDR_CAP) begin
        Seq_PktLen  <= hdrLen;
        Seq_PktType <= hdrType;
        wordsLeft   <= geom.words;
        lastMod     <= geom.lastMod[MOD_W-1:0];
        sopPend     <= 1'b1;
      end else if (rdData) begin
        wordsLeft <= wordsLeft - 16'd1;
        sopPend   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/chopper_fifo_scheduler.md
Name: chopper_fifo_scheduler

Overview:
Read-side controller for the two ping-pong sub-packet FIFOs between receive_packet and out_packet. It picks which FIFO to drain, one complete sub-packet at a time, with packet-granular round-robin. It parses the header word, sequences the FIFO read strobes, and emits framing (Val/Sop/Eop/Mod) plus the packet length and type. It replaces ad-hoc read arbitration in out_packet and is the single owner of fifo0_rd and fifo1_rd.

Parameters:
DAT_WIDTH, 64, FIFO and output word width in bits (16, 32 or 64)
MAX_PKT_LEN, 16'd9600, largest legal sub-packet length in bytes; a larger header length is an error

Ports:
Clk  in  1  block clock
Rst  in  1  asynchronous reset, active-high
fifo0_empty  in  1  FIFO0 has no words
fifo0_busy  in  1  writer is still filling FIFO0 (packet incomplete)
fifo0_rd  out  1  FIFO0 read strobe; data is valid 1 cycle later
fifo0_data_out  in  DAT_WIDTH  FIFO0 read data
fifo1_empty  in  1  FIFO1 has no words
fifo1_busy  in  1  writer is still filling FIFO1
fifo1_rd  out  1  FIFO1 read strobe
fifo1_data_out  in  DAT_WIDTH  FIFO1 read data
Seq_Rdy  in  1  downstream can accept a word (1 word of slack guaranteed)
Seq_Val  out  1  Seq_Dat valid
Seq_Sop  out  1  first payload word of sub-packet
Seq_Eop  out  1  last payload word of sub-packet
Seq_Mod  out  $clog2(DAT_WIDTH/8)+1  valid bytes in the word (BYTES on non-Eop words)
Seq_Dat  out  DAT_WIDTH  payload word (muxed from the selected FIFO)
Seq_PktLen  out  16  header length in bytes; held from header capture to the next header
Seq_PktType  out  8  header type; held likewise
Seq_Sel  out  1  FIFO currently owned (0/1)
Seq_Error  out  1  one-cycle pulse on a protocol error

Behaviour:
- BYTES = DAT_WIDTH/8.
- Header word layout: [15:0] length in bytes, [23:16] type; remaining bits are ignored.
- Payload words = ceil(len/BYTES).
- Reset (async): state IDLE; all strobes, Val, Sop, Eop and Error = 0; Mod, Dat, PktLen and PktType = 0; Seq_Sel = 0; round-robin pointer = 0 (FIFO0 preferred first).
- Eligibility: FIFOn is eligible when !fifoN_empty && !fifoN_busy.
- IDLE:
  - If both FIFOs are eligible, take the one the pointer selects.
  - If only one is eligible, take it.
  - Latch Seq_Sel, then go to HDR_RD.
- HDR_RD: assert rd for exactly 1 cycle, then go to HDR_CAP.
- HDR_CAP: capture length, type and word count.
  - Length 0 or length > MAX_PKT_LEN: pulse Error, toggle the pointer, go to IDLE. No payload is read; the FIFO is left for the writer to flush.
  - Otherwise go to DATA.
- DATA:
  - rd is asserted in any cycle where Seq_Rdy=1, the selected FIFO is !empty, and the words-remaining count is > 0.
  - Each rd decrements the count.
  - Seq_Val is rd delayed by 1 cycle. Seq_Dat is the selected FIFO's data_out in that cycle.
  - Sop accompanies the first Val of the packet.
  - Eop and Mod accompany the last Val. Mod = len mod BYTES, with 0 mapped to BYTES.
  - A single-word packet has Sop=Eop=1 on the same Val.
- DONE: entered in the cycle after the last rd, so that Eop appears in this cycle. Toggle the pointer, go to IDLE.
  - The next header rd can occur no earlier than 2 cycles after Eop.
- Underrun: the selected FIFO is empty while count > 0 and busy=0.
  - Pulse Error, suppress Eop, return to IDLE, toggle the pointer.
  - If busy=1, simply wait; this is not an error.
- Backpressure: when Seq_Rdy drops, at most one in-flight word still emits Val on the next cycle.
- Never more than one rd per cycle; fifo0_rd and fifo1_rd are never asserted together.
- Eligibility changes during DATA have no effect; the grant is held until DONE or an error.
- Reset mid-packet aborts immediately; FIFO contents are not touched.

Decomposition:
- Shared package chopper_pkg holds:
  - header field constants: LEN_LSB=0, LEN_MSB=15, TYPE_LSB=16, TYPE_MSB=23;
  - the FSM state encoding: IDLE, HDR_RD, HDR_CAP, DATA, DONE;
  - a function to compute the word count and Mod from the length.
- One natural sub-module: rr_arb2. It is a 2-requester packet-granular round-robin with req[1:0], an advance pulse, and a one-hot grant.

Test Plan:
- DAT_WIDTH=64, FIFO0 holds header len=20/type=0x5A plus 3 words, FIFO1 empty -> 3 Val. Sop on the 1st word, Eop on the 3rd with Mod=4. PktLen=20, PktType=0x5A.
- Both FIFOs hold one packet each (len=8 and len=16), Seq_Rdy=1 -> FIFO0's packet first (1 word, Sop=Eop, Mod=8), then FIFO1's (2 words). Seq_Sel goes 0 then 1, and the pointer returns to 0.
- FIFO0 len=64 (8 words), Seq_Rdy toggles 1/0 every cycle -> exactly 8 Val, no data loss or duplication, Eop on the 8th word, Mod=8.
- FIFO1 header len=0 -> Error pulses for 1 cycle 2 cycles after rd, no payload rd occurs, next grant goes to FIFO0.
- FIFO0 is busy=1 but not empty, FIFO1 is complete -> FIFO1 is granted first. If FIFO0's busy falls mid-packet, FIFO0 is served only after FIFO1's Eop.
- Rst asserted in DATA after 2 of 5 words -> all outputs are 0 on the same edge. After release with the FIFOs refilled, the state is IDLE and FIFO0 is preferred first.
